// File: rtl/branch_predict_ctrl_pkg.sv
// Shared branch opcode fields and predictor counter encodings.
// Pure definitions plus a counter-update helper; no state.
// Imported by the predictor top and the branch comparator.
package branch_predict_ctrl_pkg;

  // Conditional-branch func3 encodings
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Two-bit saturating counter states; MSB is the taken prediction
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Move one step toward the resolved direction, saturating at both ends
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'b01;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_cmp.sv
// Branch comparator: resolves conditional-branch direction from func3 and operands.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module branch_predict_ctrl_cmp
  import branch_predict_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_func3,
  input  logic [WIDTH-1:0] i_rs1,
  input  logic [WIDTH-1:0] i_rs2,
  output logic             o_taken
);

  // Direction decode; reserved func3 values (010/011) resolve not-taken
  always_comb begin
    o_taken = 1'b0;
    case (i_func3)
      F3_BEQ:  o_taken = (i_rs1 == i_rs2);
      F3_BNE:  o_taken = (i_rs1 != i_rs2);
      F3_BLT:  o_taken = ($signed(i_rs1) <  $signed(i_rs2));
      F3_BGE:  o_taken = ($signed(i_rs1) >= $signed(i_rs2));
      F3_BLTU: o_taken = (i_rs1 <  i_rs2);
      F3_BGEU: o_taken = (i_rs1 >= i_rs2);
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Bimodal branch predictor with execute-stage resolution and mispredict redirect.
// Latency: prediction combinational; redirect one cycle after the resolving edge.
// Backpressure: ex_stall freezes resolution; the redirect cycle shadows wrong-path branches.
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int BHT_ENTRIES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] if_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_stall,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [2:0]       ex_func3,
  input  logic [WIDTH-1:0] ex_rs1,
  input  logic [WIDTH-1:0] ex_rs2,
  input  logic [WIDTH-1:0] ex_target,
  input  logic             ex_pred_taken,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [31:0]      branch_count,
  output logic [31:0]      mispredict_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       r_bht [BHT_ENTRIES];
  logic             r_shadow;
  logic             r_redirect_valid;
  logic [WIDTH-1:0] r_redirect_pc;
  logic [31:0]      r_branch_count;
  logic [31:0]      r_mispredict_count;

  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic             w_taken;
  logic             w_resolve;
  logic             w_mispredict;
  logic             w_unused_if_pc;

  // Word-aligned PCs: drop the two byte-offset bits before indexing
  assign w_if_idx       = if_pc[IDX_W+1:2];
  assign w_ex_idx       = ex_pc[IDX_W+1:2];
  assign w_unused_if_pc = ^if_pc;

  branch_predict_ctrl_cmp #(.WIDTH(WIDTH)) u_cmp (
    .i_func3 (ex_func3),
    .i_rs1   (ex_rs1),
    .i_rs2   (ex_rs2),
    .o_taken (w_taken)
  );

  // The redirect cycle is wrong-path, so nothing resolves while shadow is set
  assign w_resolve    = ex_valid & ex_is_branch & ~ex_stall & ~r_shadow;
  assign w_mispredict = w_resolve & (w_taken != ex_pred_taken);

  // Lookup reads the registered table, so a same-cycle update is seen next cycle
  assign pred_taken = r_bht[w_if_idx][1];

  // Train the indexed counter toward the resolved direction
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= CTR_WNT;
    end else if (w_resolve) begin
      r_bht[w_ex_idx] <= ctr_next(r_bht[w_ex_idx], w_taken);
    end
  end

  // One-cycle redirect strobe; corrected PC held at zero when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_shadow         <= 1'b0;
    end else begin
      r_redirect_valid <= w_mispredict;
      r_shadow         <= w_mispredict;
      if (w_mispredict) r_redirect_pc <= w_taken ? ex_target : (ex_pc + WIDTH'(4));
      else              r_redirect_pc <= '0;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_resolve && (r_branch_count != 32'hFFFF_FFFF))
        r_branch_count <= r_branch_count + 32'd1;
      if (w_mispredict && (r_mispredict_count != 32'hFFFF_FFFF))
        r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

  assign redirect_valid   = r_redirect_valid;
  assign redirect_pc      = r_redirect_pc;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: doc/branch_predict_ctrl.md
BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath/PC width.
REQ-002 SHALL have parameter BHT_ENTRIES, default 16, predictor table depth (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port if_pc  input  WIDTH  fetch-stage PC, used for prediction lookup.
REQ-006 SHALL have port pred_taken  output  1  combinational prediction for if_pc.
REQ-007 SHALL have port ex_valid  input  1  execute-stage instruction valid.
REQ-008 SHALL have port ex_is_branch  input  1  execute-stage instruction is a conditional branch.
REQ-009 SHALL have port ex_stall  input  1  execute stage frozen this cycle.
REQ-010 SHALL have port ex_pc  input  WIDTH  PC of execute-stage branch.
REQ-011 SHALL have port ex_func3  input  3  branch func3 field.
REQ-012 SHALL have ports ex_rs1, ex_rs2  input  WIDTH  branch operands.
REQ-013 SHALL have port ex_target  input  WIDTH  computed branch target.
REQ-014 SHALL have port ex_pred_taken  input  1  prediction carried with the branch from fetch.
REQ-015 SHALL have port redirect_valid  output  1  registered mispredict redirect strobe.
REQ-016 SHALL have port redirect_pc  output  WIDTH  corrected fetch PC, valid with redirect_valid.
REQ-017 SHALL have ports branch_count, mispredict_count  output  32  performance counters.

Function
REQ-018 SHALL index the table with PC[log2(BHT_ENTRIES)+1:2] for both lookup and update.
REQ-019 SHALL hold one 2-bit saturating counter per entry: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; pred_taken = counter MSB.
REQ-020 SHALL resolve direction via the branch comparator (BEQ/BNE/BLT/BGE signed, BLTU/BGEU unsigned); func3 010/011 resolve not-taken.
REQ-021 SHALL define resolve = ex_valid & ex_is_branch & ~ex_stall & ~shadow.
REQ-022 SHALL, on resolve, increment the indexed counter if taken (saturating at 11), else decrement (saturating at 00).
REQ-023 SHALL, on resolve, increment branch_count; on resolve with taken != ex_pred_taken, increment mispredict_count; both saturate at 0xFFFFFFFF.
REQ-024 SHALL assert redirect_valid exactly one cycle after a mispredicting resolve, for one cycle.
REQ-025 SHALL drive redirect_pc = ex_target for actual-taken mispredicts, ex_pc+4 (modulo 2^WIDTH) for actual-not-taken mispredicts.
REQ-026 SHALL set shadow for the cycle redirect_valid is high; branches presented during shadow cause no table, counter, or redirect update (wrong-path).
REQ-027 SHALL return the pre-update counter value on lookup when lookup and update hit the same entry in the same cycle (no bypass).
REQ-028 SHALL hold redirect_valid/redirect_pc low/zero when not redirecting.
REQ-029 SHALL ignore ex_target/ex_rs1/ex_rs2 when resolve is low.

Reset
REQ-030 SHALL, on rst, set all counters to 01, redirect_valid 0, redirect_pc 0, shadow 0, branch_count 0, mispredict_count 0.
REQ-031 SHALL, with rst mid-operation, drop any pending redirect; rst has priority over resolve in the same cycle.

Structure
REQ-032 SHALL take func3 branch encodings from the shared opcode header; counter state encodings SHALL be defined there as constants.
REQ-033 SHALL instantiate the existing branch comparator as its single sub-module for direction resolution.

Verification
REQ-034 Reset, then if_pc=0x00000040 -> pred_taken=0; counters 0.
REQ-035 BEQ rs1=rs2=5, ex_pred_taken=0, pc=0x100, target=0x200 -> next cycle redirect_valid=1, redirect_pc=0x200; mispredict_count=1; pc 0x100 entry now 10.
REQ-036 BLT rs1=0xFFFFFFFF, rs2=1, pred=1 -> taken, no redirect; repeat 3x -> entry saturates at 11, branch_count=3.
REQ-037 BLTU rs1=0xFFFFFFFF, rs2=1, pred=1, pc=0x7C -> not taken; redirect_pc=0x80 next cycle; branch presented in shadow cycle -> no counter change.
REQ-038 Resolve with ex_stall=1 -> no update; rst asserted in mispredict cycle -> redirect_valid stays 0, counters 0.
REQ-039 Lookup and update same index same cycle -> pred_taken reflects old value; new value visible next cycle.
